// File: rtl/mux_scan_seq_pkg.sv
// Shared definitions for the scanning N:1 registered multiplexer.
package mux_scan_seq_pkg;

  // Sequencer states: manual select, automatic scan, nothing enabled to scan.
  typedef enum logic [1:0] {
    S_MAN  = 2'd0,
    S_SCAN = 2'd1,
    S_NONE = 2'd2
  } state_e;

  // Values of the mode input.
  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/mux_scan_seq_next_ch.sv
// Rotating priority finder: returns the first enabled channel starting at
// (inclusive) or just after (exclusive) a start index, wrapping at N_CH.
// In exclusive mode the start channel itself is the last candidate, so a
// single enabled channel finds itself.
module mux_scan_seq_next_ch #(
  parameter int N_CH  = 6,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  en_mask,
  input  logic [SEL_W-1:0] start,
  input  logic             incl,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  int               cand_s;
  logic [SEL_W-1:0] idx_s;

  // Walk all N_CH candidates in rotating order and keep the first enabled one.
  always_comb begin
    nxt    = '0;
    found  = 1'b0;
    cand_s = 0;
    idx_s  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand_s = (int'(start) + i + int'(!incl)) % N_CH;
      idx_s  = cand_s[SEL_W-1:0];
      if (!found && en_mask[idx_s]) begin
        nxt   = idx_s;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// Parametrised N:1 registered multiplexer with a scanning channel sequencer.
// Manual mode follows sel; scan mode walks the enabled channels, DWELL
// cycles each. dout and cur_ch are registered together so cur_ch always
// names the channel that dout came from.
module mux_scan_seq
  import mux_scan_seq_pkg::*;
#(
  parameter  int N_CH  = 6,
  parameter  int WIDTH = 1,
  parameter  int DWELL = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic [N_CH-1:0]       en_mask,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic [SEL_W-1:0]      cur_ch
);

  localparam int               DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W:0]   NCH_EXT    = (SEL_W + 1)'(N_CH);

  state_e            state_r, state_nxt_s;
  logic [SEL_W-1:0]  cur_ch_r, ch_nxt_s;
  logic [DW_W-1:0]   dwell_r, dwell_nxt_s;
  logic [WIDTH-1:0]  dout_r, dout_nxt_s;
  logic              dout_valid_r, valid_nxt_s;

  logic [WIDTH-1:0]  ch_s [N_CH];
  logic              any_en_s;
  logic              sel_ok_s, sel_en_s;
  logic              cur_ok_s, cur_en_s;
  logic [SEL_W-1:0]  scan_start_s;
  logic [SEL_W-1:0]  entry_ch_s, adv_ch_s;
  logic              entry_found_s, adv_found_s;

  // Unpack the flat input bus into per-channel words.
  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch_s[k] = din[k*WIDTH +: WIDTH];
  end

  assign any_en_s     = |en_mask;
  assign sel_ok_s     = ({1'b0, sel} < NCH_EXT);
  assign sel_en_s     = sel_ok_s ? en_mask[sel] : 1'b0;
  assign cur_ok_s     = ({1'b0, cur_ch_r} < NCH_EXT);
  assign cur_en_s     = cur_ok_s ? en_mask[cur_ch_r] : 1'b0;
  // An out-of-range select starts the scan search from channel 0.
  assign scan_start_s = sel_ok_s ? sel : '0;

  mux_scan_seq_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_entry (
    .en_mask (en_mask),
    .start   (scan_start_s),
    .incl    (1'b1),
    .nxt     (entry_ch_s),
    .found   (entry_found_s)
  );

  mux_scan_seq_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_adv (
    .en_mask (en_mask),
    .start   (cur_ch_r),
    .incl    (1'b0),
    .nxt     (adv_ch_s),
    .found   (adv_found_s)
  );

  // State register; reset forces manual mode even in the middle of a scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_MAN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode from mode and whether anything is enabled.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_MAN: begin
        if (mode == MODE_SCAN) begin
          state_nxt_s = any_en_s ? S_SCAN : S_NONE;
        end else begin
          state_nxt_s = S_MAN;
        end
      end
      S_SCAN: begin
        if (mode == MODE_MAN) begin
          state_nxt_s = S_MAN;
        end else if (!any_en_s) begin
          state_nxt_s = S_NONE;
        end else begin
          state_nxt_s = S_SCAN;
        end
      end
      S_NONE: begin
        if (mode == MODE_MAN) begin
          state_nxt_s = S_MAN;
        end else if (any_en_s) begin
          state_nxt_s = S_SCAN;
        end else begin
          state_nxt_s = S_NONE;
        end
      end
      default: state_nxt_s = S_MAN;
    endcase
  end

  // Output decode: choose the channel to present after this edge, the new
  // dwell count, and the data/valid that go with that channel.
  always_comb begin
    ch_nxt_s    = cur_ch_r;
    dwell_nxt_s = '0;
    dout_nxt_s  = '0;
    valid_nxt_s = 1'b0;
    case (state_nxt_s)
      S_MAN: begin
        ch_nxt_s = sel;
        if (sel_ok_s && sel_en_s) begin
          dout_nxt_s  = ch_s[sel];
          valid_nxt_s = 1'b1;
        end else begin
          dout_nxt_s  = '0;
          valid_nxt_s = 1'b0;
        end
      end
      S_SCAN: begin
        if (state_r != S_SCAN) begin
          ch_nxt_s    = entry_ch_s;
          dwell_nxt_s = '0;
          valid_nxt_s = entry_found_s;
        end else if (!cur_en_s || (dwell_r == DWELL_LAST)) begin
          // Current channel masked off or its dwell is over: move on.
          ch_nxt_s    = adv_ch_s;
          dwell_nxt_s = '0;
          valid_nxt_s = adv_found_s;
        end else begin
          ch_nxt_s    = cur_ch_r;
          dwell_nxt_s = dwell_r + DW_W'(1);
          valid_nxt_s = 1'b1;
        end
        if (valid_nxt_s) begin
          dout_nxt_s = ch_s[ch_nxt_s];
        end else begin
          dout_nxt_s = '0;
        end
      end
      S_NONE: begin
        ch_nxt_s    = cur_ch_r;
        dwell_nxt_s = '0;
        dout_nxt_s  = '0;
        valid_nxt_s = 1'b0;
      end
      default: begin
        ch_nxt_s    = '0;
        dwell_nxt_s = '0;
        dout_nxt_s  = '0;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and dwell registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      cur_ch_r     <= '0;
      dwell_r      <= '0;
    end else begin
      dout_r       <= dout_nxt_s;
      dout_valid_r <= valid_nxt_s;
      cur_ch_r     <= ch_nxt_s;
      dwell_r      <= dwell_nxt_s;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign cur_ch     = cur_ch_r;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq: one instance with DWELL=4 and one with
// DWELL=1 driven by the same stimulus.
module tb_mux_scan_seq;

  logic       clk;
  logic       rst;
  logic [5:0] din;
  logic [2:0] sel;
  logic       mode;
  logic [5:0] en_mask;
  logic       dout4, valid4, dout1, valid1;
  logic [2:0] cur4, cur1;

  int n_chk;
  int n_fail;

  logic [2:0] seq  [4];
  logic [2:0] seq2 [4];
  logic [0:0] man_exp [6];
  logic [2:0] e_ch;

  mux_scan_seq #(.N_CH(6), .WIDTH(1), .DWELL(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .sel        (sel),
    .mode       (mode),
    .en_mask    (en_mask),
    .dout       (dout4),
    .dout_valid (valid4),
    .cur_ch     (cur4)
  );

  mux_scan_seq #(.N_CH(6), .WIDTH(1), .DWELL(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .sel        (sel),
    .mode       (mode),
    .en_mask    (en_mask),
    .dout       (dout1),
    .dout_valid (valid1),
    .cur_ch     (cur1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    seq     = '{3'd0, 3'd2, 3'd3, 3'd5};
    seq2    = '{3'd3, 3'd5, 3'd0, 3'd2};
    man_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset
    rst = 1'b1; din = 6'b111010; sel = 3'd0; mode = 1'b0; en_mask = 6'h3F;
    tick(); tick();
    chk("rst_dout", dout4, 0);
    chk("rst_valid", valid4, 0);
    chk("rst_cur", cur4, 0);
    chk("rst_dout_d1", dout1, 0);
    rst = 1'b0;

    // Manual select of every channel
    for (int s = 0; s < 6; s++) begin
      sel = 3'(s);
      tick();
      chk("man_dout", dout4, man_exp[s]);
      chk("man_valid", valid4, 1);
      chk("man_cur", cur4, s);
      repeat (9) tick();
      chk("man_hold", dout4, man_exp[s]);
    end

    // Out-of-range and masked selects
    sel = 3'd6; tick();
    chk("oor6_dout", dout4, 0); chk("oor6_valid", valid4, 0); chk("oor6_cur", cur4, 6);
    sel = 3'd7; tick();
    chk("oor7_dout", dout4, 0); chk("oor7_valid", valid4, 0); chk("oor7_cur", cur4, 7);
    sel = 3'd2; en_mask = 6'b111011; tick();
    chk("mask_valid", valid4, 0); chk("mask_dout", dout4, 0); chk("mask_cur", cur4, 2);

    // Scan over channels 0,2,3,5
    en_mask = 6'b101101; sel = 3'd0; din = 6'b000100; mode = 1'b1;
    for (int k = 0; k < 26; k++) begin
      tick();
      e_ch = seq[(k / 4) % 4];
      chk("scan_cur", cur4, e_ch);
      chk("scan_dout", dout4, (e_ch == 3'd2) ? 1 : 0);
      chk("scan_valid", valid4, 1);
      chk("scan_cur_d1", cur1, seq[k % 4]);
    end

    // Now on ch3 mid-dwell: mask it off
    en_mask = 6'b100101; din = 6'b100000;
    tick();
    chk("adv_cur", cur4, 5); chk("adv_dout", dout4, 1); chk("adv_valid", valid4, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("adv_hold", cur4, 5);
    end
    en_mask = 6'b000000;
    tick();
    chk("none_valid", valid4, 0); chk("none_dout", dout4, 0); chk("none_cur", cur4, 5);
    tick();
    chk("none_cur2", cur4, 5); chk("none_valid2", valid4, 0);

    // Re-enter scan, then reset in the middle of it
    en_mask = 6'b101101; din = 6'b000100; sel = 3'd0;
    tick();
    chk("reent_cur", cur4, 0); chk("reent_cur_d1", cur1, 0);
    tick();
    chk("reent2_cur", cur4, 0); chk("reent2_cur_d1", cur1, 2);
    rst = 1'b1;
    tick();
    chk("mrst_dout", dout4, 0); chk("mrst_valid", valid4, 0); chk("mrst_cur", cur4, 0);
    chk("mrst_valid_d1", valid1, 0); chk("mrst_cur_d1", cur1, 0);
    rst = 1'b0; sel = 3'd3;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rs_cur", cur4, (k < 4) ? 3 : 5);
      e_ch = seq2[k % 4];
      chk("rs_cur_d1", cur1, e_ch);
      chk("rs_dout_d1", dout1, (e_ch == 3'd2) ? 1 : 0);
      chk("rs_valid_d1", valid1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
